// File: rtl/parking_keypad_entry_if.sv
// Password handoff and verdict bus between the entrance keypad and the gate controller.
interface parking_keypad_entry_if;
  logic       pw_valid;
  logic       pw_ready;
  logic [1:0] password_1;
  logic [1:0] password_2;
  logic       result_valid;
  logic       result_ok;

  modport master (
    output pw_valid, password_1, password_2,
    input  pw_ready, result_valid, result_ok
  );

  modport slave (
    input  pw_valid, password_1, password_2,
    output pw_ready, result_valid, result_ok
  );
endinterface

// File: rtl/parking_keypad_entry.sv
// Entrance keypad: collects two digits, offers them to the gate controller,
// tracks failed verdicts and locks the keypad out after repeated failures.
module parking_keypad_entry #(
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned MAX_ATTEMPTS   = 3,
  parameter int unsigned LOCKOUT_CYCLES = 5000
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                car_present,
  input  logic                                key_valid,
  input  logic [1:0]                          key_digit,
  input  logic                                key_clear,
  parking_keypad_entry_if.master              pw,
  output logic                                locked,
  output logic [$clog2(MAX_ATTEMPTS+1)-1:0]   attempts,
  output logic [2:0]                          state
);

  localparam int unsigned TIMER_MAX = (TIMEOUT_CYCLES > LOCKOUT_CYCLES) ? TIMEOUT_CYCLES
                                                                        : LOCKOUT_CYCLES;
  localparam int unsigned TW = $clog2(TIMER_MAX + 1);
  localparam int unsigned AW = $clog2(MAX_ATTEMPTS + 1);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    DIGIT1      = 3'd1,
    DIGIT2      = 3'd2,
    SEND        = 3'd3,
    WAIT_RESULT = 3'd4,
    DONE        = 3'd5,
    LOCKED      = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    pw1_q, pw1_d;
  logic [1:0]    pw2_q, pw2_d;
  logic [AW-1:0] att_q, att_d;
  logic          pw_valid_q;
  logic          locked_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      pw1_q      <= '0;
      pw2_q      <= '0;
      att_q      <= '0;
      pw_valid_q <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      pw1_q      <= pw1_d;
      pw2_q      <= pw2_d;
      att_q      <= att_d;
      // Flags follow the next state so they are registered yet aligned with it.
      pw_valid_q <= (state_d == SEND);
      locked_q   <= (state_d == LOCKED);
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    pw1_d   = pw1_q;
    pw2_d   = pw2_q;
    att_d   = att_q;

    unique case (state_q)
      IDLE: begin
        timer_d = '0;
        if (car_present) state_d = DIGIT1;
      end

      DIGIT1, DIGIT2: begin
        timer_d = timer_q + TW'(1);
        if (!car_present) begin
          state_d = IDLE;
          timer_d = '0;
          pw1_d   = '0;
          pw2_d   = '0;
        end else if (key_clear) begin
          timer_d = '0;
          if (state_q == DIGIT2) begin
            pw1_d   = '0;
            state_d = DIGIT1;
          end
        end else if (key_valid) begin
          timer_d = '0;
          if (state_q == DIGIT1) begin
            pw1_d   = key_digit;
            state_d = DIGIT2;
          end else begin
            pw2_d   = key_digit;
            state_d = SEND;
          end
        end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d = IDLE;
          timer_d = '0;
          pw1_d   = '0;
          pw2_d   = '0;
        end
      end

      SEND: begin
        timer_d = '0;
        if (pw_valid_q && pw.pw_ready) state_d = WAIT_RESULT;
      end

      WAIT_RESULT: begin
        timer_d = '0;
        if (pw.result_valid) begin
          pw1_d = '0;
          pw2_d = '0;
          if (pw.result_ok) begin
            att_d   = '0;
            state_d = DONE;
          end else if (att_q + AW'(1) == AW'(MAX_ATTEMPTS)) begin
            att_d   = '0;
            state_d = LOCKED;
          end else begin
            att_d   = att_q + AW'(1);
            state_d = DIGIT1;
          end
        end
      end

      DONE: begin
        timer_d = '0;
        if (!car_present) state_d = IDLE;
      end

      LOCKED: begin
        timer_d = timer_q + TW'(1);
        if (timer_q == TW'(LOCKOUT_CYCLES - 1)) begin
          timer_d = '0;
          att_d   = '0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        timer_d = '0;
        pw1_d   = '0;
        pw2_d   = '0;
      end
    endcase
  end

  assign pw.pw_valid   = pw_valid_q;
  assign pw.password_1 = pw1_q;
  assign pw.password_2 = pw2_q;
  assign locked        = locked_q;
  assign attempts      = att_q;
  assign state         = state_q;

endmodule
